// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_stage_reg                                             |
// | Description : Parametrised pipeline boundary register. Carries a valid   |
// |               bit, a control bundle and a data bundle through STAGES     |
// |               back-to-back register slices, with hazard-unit stall       |
// |               (hold) and flush (bubble insertion).                       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   CTRL_W   control bundle width                                          |
// |   DATA_W   data bundle width                                             |
// |   STAGES   register slices in series, legal range 1..4                   |
// |   CNT_W    width of the stall/flush statistic counters                   |
// | Ports                                                                    |
// |   Clk         in   rising-edge clock                                     |
// |   Rst         in   synchronous reset, active-high                        |
// |   Stall       in   hold every slice this cycle                           |
// |   Flush       in   turn every slice into a bubble this cycle             |
// |   InValid     in   upstream slot holds a real instruction                |
// |   InCtrl      in   upstream control bundle                               |
// |   InData      in   upstream data bundle                                  |
// |   OutValid    out  last slice valid                                      |
// |   OutCtrl     out  last slice control bundle                             |
// |   OutData     out  last slice data bundle                                |
// |   StallCount  out  saturating count of stall cycles                      |
// |   FlushCount  out  saturating count of flush cycles                      |
// | Build option                                                             |
// |   PIPE_STAGE_STATS_EN  defined   : statistic counters are implemented   |
// |                        undefined : StallCount/FlushCount tied to zero   |
// +--------------------------------------------------------------------------+
module pipe_stage_reg #(
   parameter int CTRL_W = 9,
   parameter int DATA_W = 192,
   parameter int STAGES = 1,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Stall,
   input  logic              Flush,
   input  logic              InValid,
   input  logic [CTRL_W-1:0] InCtrl,
   input  logic [DATA_W-1:0] InData,
   output logic              OutValid,
   output logic [CTRL_W-1:0] OutCtrl,
   output logic [DATA_W-1:0] OutData,
   output logic [CNT_W-1:0]  StallCount,
   output logic [CNT_W-1:0]  FlushCount
);

   // ------------------------------------------------------------------------
   // Register slices. Each slice owns its own valid/ctrl/data flops and picks
   // up its feed either from the upstream ports (slice 0) or from the slice
   // in front of it. Stall and Flush act on all slices in the same cycle.
   // ------------------------------------------------------------------------
   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      logic              valid;
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;

      logic              feed_valid;
      logic [CTRL_W-1:0] feed_ctrl;
      logic [DATA_W-1:0] feed_data;

      if (k == 0) begin : g_head
         // A bubble must never carry live control (memwrite/regwrite) into
         // later stages, so control is gated by InValid. Data is left as-is
         // because it is a don't-care in a bubble and gating it costs toggles.
         assign feed_valid = InValid;
         assign feed_ctrl  = InCtrl & {CTRL_W{InValid}};
         assign feed_data  = InData;
      end else begin : g_tail
         assign feed_valid = g_slice[k-1].valid;
         assign feed_ctrl  = g_slice[k-1].ctrl;
         assign feed_data  = g_slice[k-1].data;
      end

      // Priority: Rst > Flush > Stall > advance. Flush clears only valid and
      // ctrl; the data flops keep their value so a flush does not toggle the
      // wide data bus.
      always_ff @(posedge Clk) begin
         if (Rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
         end else if (Flush) begin
            valid <= 1'b0;
            ctrl  <= '0;
         end else if (!Stall) begin
            valid <= feed_valid;
            ctrl  <= feed_ctrl;
            data  <= feed_data;
         end
      end
   end

   // Outputs come straight from the last slice flops.
   assign OutValid = g_slice[STAGES-1].valid;
   assign OutCtrl  = g_slice[STAGES-1].ctrl;
   assign OutData  = g_slice[STAGES-1].data;

   // ------------------------------------------------------------------------
   // Optional statistic counters. A cycle with both Stall and Flush is a
   // flush (flush wins), so it is counted only as a flush. Both counters
   // saturate rather than wrap and are cleared only by reset.
   // ------------------------------------------------------------------------
`ifdef PIPE_STAGE_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         stall_count <= '0;
         flush_count <= '0;
      end else if (Flush) begin
         if (flush_count != CNT_MAX) begin
            flush_count <= flush_count + 1'b1;
         end
      end else if (Stall) begin
         if (stall_count != CNT_MAX) begin
            stall_count <= stall_count + 1'b1;
         end
      end
   end

   assign StallCount = stall_count;
   assign FlushCount = flush_count;
`else
   assign StallCount = '0;
   assign FlushCount = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pipe_stage_reg                                          |
// | Description : Scoreboard bench for pipe_stage_reg. Two instances share   |
// |               one stimulus stream: dut_a (STAGES=3, CNT_W=4) and dut_b   |
// |               (STAGES=1, CNT_W=16). Directed vectors push hand-computed  |
// |               expected outputs, tagged with the edge at which they must  |
// |               appear; a monitor pops and compares on each falling edge.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_pipe_stage_reg;
   localparam int CTRL_W  = 9;
   localparam int DATA_W  = 192;
   localparam int CNT_W_A = 4;
   localparam int CNT_W_B = 16;

   logic              Clk = 1'b0;
   logic              Rst;
   logic              Stall;
   logic              Flush;
   logic              InValid;
   logic [CTRL_W-1:0] InCtrl;
   logic [DATA_W-1:0] InData;

   logic              a_valid;
   logic [CTRL_W-1:0] a_ctrl;
   logic [DATA_W-1:0] a_data;
   logic [CNT_W_A-1:0] a_scnt;
   logic [CNT_W_A-1:0] a_fcnt;

   logic              b_valid;
   logic [CTRL_W-1:0] b_ctrl;
   logic [DATA_W-1:0] b_data;
   logic [CNT_W_B-1:0] b_scnt;
   logic [CNT_W_B-1:0] b_fcnt;

   int cyc      = 0;
   int checks   = 0;
   int errors   = 0;
   bit rst_seen = 1'b0;

   typedef struct {
      int                dut;      // 0 = dut_a, 1 = dut_b
      int                due;      // edge count at which the value is visible
      string             name;
      logic              v;
      logic [CTRL_W-1:0] c;
      logic [DATA_W-1:0] d;
      bit                chk_cnt;
      int                sc;
      int                fc;
   } exp_t;

   exp_t sb[$];

   pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .STAGES(3), .CNT_W(CNT_W_A)) dut_a (
      .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
      .InValid(InValid), .InCtrl(InCtrl), .InData(InData),
      .OutValid(a_valid), .OutCtrl(a_ctrl), .OutData(a_data),
      .StallCount(a_scnt), .FlushCount(a_fcnt)
   );

   pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .STAGES(1), .CNT_W(CNT_W_B)) dut_b (
      .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
      .InValid(InValid), .InCtrl(InCtrl), .InData(InData),
      .OutValid(b_valid), .OutCtrl(b_ctrl), .OutData(b_data),
      .StallCount(b_scnt), .FlushCount(b_fcnt)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   // Counters read zero unless the statistics option is built in.
   function automatic int cexp(input int n);
`ifdef PIPE_STAGE_STATS_EN
      return n;
`else
      return 0;
`endif
   endfunction

   // Data bundle pattern: the 32-bit word repeated across the full width.
   function automatic logic [DATA_W-1:0] mk(input logic [31:0] w);
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W; i++) r[i] = w[i % 32];
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------------
   task automatic compare(input exp_t e);
      logic              v;
      logic [CTRL_W-1:0] c;
      logic [DATA_W-1:0] d;
      logic [31:0]       sc;
      logic [31:0]       fc;
      bit                bad;
      if (e.dut == 0) begin
         v = a_valid; c = a_ctrl; d = a_data; sc = 32'(a_scnt); fc = 32'(a_fcnt);
      end else begin
         v = b_valid; c = b_ctrl; d = b_data; sc = 32'(b_scnt); fc = 32'(b_fcnt);
      end
      bad = (v !== e.v) || (c !== e.c) || (d !== e.d);
      if (e.chk_cnt && ((sc !== 32'(e.sc)) || (fc !== 32'(e.fc)))) bad = 1'b1;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL %s dut_%s edge=%0d got v=%b c=%h d=%h sc=%0d fc=%0d exp v=%b c=%h d=%h sc=%0d fc=%0d",
                  e.name, (e.dut == 0) ? "a" : "b", cyc, v, c, d, sc, fc,
                  e.v, e.c, e.d, e.sc, e.fc);
      end
   endtask

   always @(negedge Clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            compare(sb[i]);
            sb.delete(i);
         end else if (sb[i].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s missed edge=%0d due=%0d", sb[i].name, cyc, sb[i].due);
            sb.delete(i);
         end
      end
      // A slot that is not valid must never carry control.
      if (rst_seen) begin
         checks++;
         if ((!a_valid && a_ctrl !== '0) || (!b_valid && b_ctrl !== '0)) begin
            errors++;
            $display("FAIL invariant edge=%0d got a_ctrl=%h b_ctrl=%h exp 0 when invalid",
                     cyc, a_ctrl, b_ctrl);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Driver helpers
   // ------------------------------------------------------------------------
   task automatic apply(input logic rst, input logic stall, input logic flush,
                        input logic v, input logic [CTRL_W-1:0] c, input logic [31:0] w);
      Rst = rst; Stall = stall; Flush = flush;
      InValid = v; InCtrl = c; InData = mk(w);
      @(posedge Clk);
      #2;
   endtask

   task automatic push(input int dut, input int due, input string name,
                       input logic v, input logic [CTRL_W-1:0] c, input logic [31:0] w,
                       input bit chk, input int sc, input int fc);
      exp_t e;
      e.dut = dut; e.due = due; e.name = name;
      e.v = v; e.c = c; e.d = mk(w);
      e.chk_cnt = chk; e.sc = sc; e.fc = fc;
      sb.push_back(e);
   endtask

   // Normal advance. dut_b shows the item on the capture edge, dut_a two
   // edges later, unless the caller knows a stall/flush will intervene.
   task automatic send(input string name, input logic v, input logic [CTRL_W-1:0] c,
                       input logic [31:0] w, input logic [CTRL_W-1:0] c_exp, input bit push_a);
      apply(1'b0, 1'b0, 1'b0, v, c, w);
      push(1, cyc, name, v, c_exp, w, 1'b0, 0, 0);
      if (push_a) push(0, cyc + 2, name, v, c_exp, w, 1'b0, 0, 0);
   endtask

   // ------------------------------------------------------------------------
   // Directed stimulus
   // ------------------------------------------------------------------------
   initial begin
      // Reset with every other input at all-ones.
      for (int i = 0; i < 2; i++) begin
         apply(1'b1, 1'b1, 1'b1, 1'b1, '1, 32'hFFFF_FFFF);
         rst_seen = 1'b1;
         push(0, cyc, "reset", 1'b0, '0, 32'h0, 1'b1, 0, 0);
         push(1, cyc, "reset", 1'b0, '0, 32'h0, 1'b1, 0, 0);
      end

      // Latency / throughput, edges 3..10.
      send("lat_1ff", 1'b1, 9'h1FF, 32'd512, 9'h1FF, 1'b1);
      push(0, cyc,     "lat_empty", 1'b0, '0, 32'h0, 1'b1, 0, 0);
      push(0, cyc + 1, "lat_empty", 1'b0, '0, 32'h0, 1'b1, 0, 0);
      send("tput_0aa", 1'b1, 9'h0AA, 32'h1111, 9'h0AA, 1'b1);
      send("tput_133", 1'b1, 9'h133, 32'h2222, 9'h133, 1'b1);
      send("bubble_a", 1'b0, 9'h1FF, 32'hAAAA, 9'h000, 1'b1);
      send("bubble_b", 1'b0, 9'h1FF, 32'hBBBB, 9'h000, 1'b1);
      send("load_1ff", 1'b1, 9'h1FF, 32'h1FF0, 9'h1FF, 1'b1);
      send("load_0f0", 1'b1, 9'h0F0, 32'h3000, 9'h0F0, 1'b0);
      send("load_00f", 1'b1, 9'h00F, 32'h4000, 9'h00F, 1'b0);

      // Stall for 4 edges (11..14) with new upstream values that must be dropped.
      for (int k = 1; k <= 4; k++) begin
         apply(1'b0, 1'b1, 1'b0, 1'b1, 9'h055, 32'h5555);
         push(0, cyc, "stall_hold", 1'b1, 9'h1FF, 32'h1FF0, 1'b1, cexp(k), 0);
         push(1, cyc, "stall_hold", 1'b1, 9'h00F, 32'h4000, 1'b1, cexp(k), 0);
      end

      // Release at edge 15.
      send("release_055", 1'b1, 9'h055, 32'h5555, 9'h055, 1'b0);
      push(0, cyc, "release_0f0", 1'b1, 9'h0F0, 32'h3000, 1'b0, 0, 0);

      // Flush together with stall at edge 16: bubbles, data held.
      apply(1'b0, 1'b1, 1'b1, 1'b1, 9'h1FF, 32'h6666);
      push(0, cyc, "flush_stall", 1'b0, '0, 32'h3000, 1'b1, cexp(4), cexp(1));
      push(1, cyc, "flush_stall", 1'b0, '0, 32'h5555, 1'b1, cexp(4), cexp(1));

      // Flushed slices drain out of dut_a as bubbles with their old data.
      send("post_flush_123", 1'b1, 9'h123, 32'h7777, 9'h123, 1'b1);
      push(0, cyc,     "flushed_s1", 1'b0, '0, 32'h4000, 1'b0, 0, 0);
      push(0, cyc + 1, "flushed_s0", 1'b0, '0, 32'h5555, 1'b0, 0, 0);
      send("bubble_9999", 1'b0, 9'h1FF, 32'h9999, 9'h000, 1'b1);
      send("load_1c3",    1'b1, 9'h1C3, 32'hABCD, 9'h1C3, 1'b1);
      send("idle_0",      1'b0, 9'h000, 32'h0,    9'h000, 1'b0);
      send("idle_1",      1'b0, 9'h000, 32'h0,    9'h000, 1'b0);

      // Long stall, edges 22..41: dut_a counter saturates at 15, dut_b reaches 24.
      for (int k = 1; k <= 20; k++) begin
         apply(1'b0, 1'b1, 1'b0, 1'b1, 9'h1FF, 32'hFFFF);
         push(0, cyc, "sat_stall", 1'b1, 9'h1C3, 32'hABCD, 1'b1,
              cexp((4 + k > 15) ? 15 : 4 + k), cexp(1));
         push(1, cyc, "sat_stall", 1'b0, '0, 32'h0, 1'b1, cexp(4 + k), cexp(1));
      end

      // Reset in the middle of stall and flush, edge 42.
      apply(1'b1, 1'b1, 1'b1, 1'b1, '1, 32'hFFFF_FFFF);
      push(0, cyc, "reset_mid", 1'b0, '0, 32'h0, 1'b1, 0, 0);
      push(1, cyc, "reset_mid", 1'b0, '0, 32'h0, 1'b1, 0, 0);

      // Traffic resumes cleanly after reset.
      send("after_rst_055", 1'b1, 9'h055, 32'h1234, 9'h055, 1'b1);
      push(0, cyc,     "after_rst_empty", 1'b0, '0, 32'h0, 1'b1, 0, 0);
      push(0, cyc + 1, "after_rst_empty", 1'b0, '0, 32'h0, 1'b1, 0, 0);
      send("tail_0", 1'b0, 9'h000, 32'h0, 9'h000, 1'b0);
      send("tail_1", 1'b0, 9'h000, 32'h0, 9'h000, 1'b0);

      // Bounded wait for the scoreboard to empty.
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge Clk);
      @(negedge Clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain got %0d pending entries exp 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
